// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between a CPU port and a VGA fetch port.
// Issued reads are tagged in an in-order FIFO so returning data reaches the right requester.
module sdram_port_arbiter #(
  parameter int ADDR_W       = 22,
  parameter int DATA_W       = 16,
  parameter int VGA_BURST    = 8,
  parameter int STARVE_LIMIT = 16,
  parameter int MAX_PENDING  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic [DATA_W-1:0] cpu_writedata,
  input  logic [1:0]        cpu_byteenable,
  input  logic              cpu_read,
  input  logic              cpu_write,
  output logic              cpu_waitrequest,
  output logic [DATA_W-1:0] cpu_readdata,
  output logic              cpu_readdatavalid,
  input  logic [ADDR_W-1:0] vga_address,
  input  logic              vga_read,
  output logic              vga_waitrequest,
  output logic [DATA_W-1:0] vga_readdata,
  output logic              vga_readdatavalid,
  output logic [ADDR_W-1:0] m_address,
  output logic [DATA_W-1:0] m_writedata,
  output logic [1:0]        m_byteenable,
  output logic              m_read,
  output logic              m_write,
  input  logic              m_waitrequest,
  input  logic [DATA_W-1:0] m_readdata,
  input  logic              m_readdatavalid,
  output logic              orphan_err
);

  localparam int PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
  localparam int CNT_W = $clog2(MAX_PENDING + 1);
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);
  localparam int BC_W  = $clog2(VGA_BURST + 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(MAX_PENDING);
  localparam logic [SC_W-1:0]  STARVE_MAX = SC_W'(STARVE_LIMIT);
  localparam logic [BC_W-1:0]  BURST_LAST = BC_W'(VGA_BURST - 1);

  typedef enum logic [1:0] {IDLE, CPU, VGA} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic [SC_W-1:0]        starve_cnt;
  logic [BC_W-1:0]        burst_cnt;
  logic [MAX_PENDING-1:0] tag_mem;
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [CNT_W-1:0]       tag_cnt;

  logic cpu_req;
  logic starved;
  logic tag_empty;
  logic tag_block;
  logic tag_push;
  logic tag_pop;
  logic head_tag;
  logic cmd_accept;

  assign cpu_req   = cpu_read | cpu_write;
  assign starved   = starve_cnt >= STARVE_MAX;
  assign tag_empty = tag_cnt == '0;
  // A full FIFO still takes a new tag when a return frees a slot in the same cycle.
  assign tag_block = (tag_cnt == FIFO_FULL) & ~m_readdatavalid;
  assign tag_pop   = m_readdatavalid & ~tag_empty;
  assign tag_push  = m_read & ~m_waitrequest;
  assign cmd_accept = (m_read | m_write) & ~m_waitrequest;
  assign head_tag  = tag_mem[rd_ptr];

  assign cpu_readdata      = m_readdata;
  assign vga_readdata      = m_readdata;
  assign cpu_readdatavalid = tag_pop & ~head_tag;
  assign vga_readdatavalid = tag_pop & head_tag;

  always_comb begin
    m_address       = cpu_address;
    m_writedata     = cpu_writedata;
    m_byteenable    = cpu_byteenable;
    m_read          = 1'b0;
    m_write         = 1'b0;
    cpu_waitrequest = 1'b1;
    vga_waitrequest = 1'b1;
    case (state)
      CPU: begin
        m_write         = cpu_write;
        m_read          = cpu_read & ~cpu_write & ~tag_block;
        cpu_waitrequest = m_waitrequest | (cpu_read & ~cpu_write & tag_block);
      end
      VGA: begin
        m_address       = vga_address;
        m_byteenable    = '1;
        m_read          = vga_read & ~tag_block;
        vga_waitrequest = m_waitrequest | (vga_read & tag_block);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (vga_read && !starved)  state_nxt = VGA;
        else if (cpu_req)          state_nxt = CPU;
        else if (vga_read)         state_nxt = VGA;
      end
      CPU: begin
        if (!cpu_req || cmd_accept) state_nxt = IDLE;
      end
      VGA: begin
        // Yield to a starved CPU only right after a read is taken, never mid-stall.
        if (!vga_read)
          state_nxt = IDLE;
        else if (cmd_accept && (burst_cnt == BURST_LAST || (cpu_req && starved)))
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starve_cnt <= '0;
      burst_cnt  <= '0;
      tag_mem    <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      tag_cnt    <= '0;
      orphan_err <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == CPU && cmd_accept)
        starve_cnt <= '0;
      else if (cpu_req && state != CPU && !starved)
        starve_cnt <= starve_cnt + SC_W'(1);

      if (state != VGA)
        burst_cnt <= '0;
      else if (cmd_accept)
        burst_cnt <= burst_cnt + BC_W'(1);

      if (tag_push) begin
        tag_mem[wr_ptr] <= (state == VGA);
        wr_ptr          <= wr_ptr + PTR_W'(1);
      end
      if (tag_pop)
        rd_ptr <= rd_ptr + PTR_W'(1);

      if (tag_push && !tag_pop)
        tag_cnt <= tag_cnt + CNT_W'(1);
      else if (!tag_push && tag_pop)
        tag_cnt <= tag_cnt - CNT_W'(1);

      if (m_readdatavalid && tag_empty)
        orphan_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Bench for sdram_port_arbiter: plays the CPU, the VGA fetcher and the SDRAM controller,
// and routes expected read data through an issue-order queue.
module tb_sdram_port_arbiter;
  localparam int ADDR_W       = 22;
  localparam int DATA_W       = 16;
  localparam int VGA_BURST    = 8;
  localparam int STARVE_LIMIT = 16;
  localparam int MAX_PENDING  = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [ADDR_W-1:0] cpu_address = '0;
  logic [DATA_W-1:0] cpu_writedata = '0;
  logic [1:0]        cpu_byteenable = '1;
  logic              cpu_read = 1'b0;
  logic              cpu_write = 1'b0;
  logic              cpu_waitrequest;
  logic [DATA_W-1:0] cpu_readdata;
  logic              cpu_readdatavalid;
  logic [ADDR_W-1:0] vga_address = '0;
  logic              vga_read = 1'b0;
  logic              vga_waitrequest;
  logic [DATA_W-1:0] vga_readdata;
  logic              vga_readdatavalid;
  logic [ADDR_W-1:0] m_address;
  logic [DATA_W-1:0] m_writedata;
  logic [1:0]        m_byteenable;
  logic              m_read;
  logic              m_write;
  logic              m_waitrequest = 1'b0;
  logic [DATA_W-1:0] m_readdata = '0;
  logic              m_readdatavalid = 1'b0;
  logic              orphan_err;

  sdram_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .VGA_BURST(VGA_BURST),
    .STARVE_LIMIT(STARVE_LIMIT), .MAX_PENDING(MAX_PENDING)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_address(cpu_address), .cpu_writedata(cpu_writedata), .cpu_byteenable(cpu_byteenable),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_waitrequest(cpu_waitrequest),
    .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid),
    .vga_address(vga_address), .vga_read(vga_read), .vga_waitrequest(vga_waitrequest),
    .vga_readdata(vga_readdata), .vga_readdatavalid(vga_readdatavalid),
    .m_address(m_address), .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_read(m_read), .m_write(m_write), .m_waitrequest(m_waitrequest),
    .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .orphan_err(orphan_err)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [DATA_W-1:0] data; } ret_t;
  typedef struct { bit vga; logic [DATA_W-1:0] data; } exp_t;

  ret_t              ret_q[$];   // controller side: data still to be returned
  exp_t              exp_q[$];   // requester side: who owns each outstanding read
  logic [DATA_W-1:0] pat_q[$];
  logic [DATA_W-1:0] cpu_got[$];
  logic [DATA_W-1:0] vga_got[$];

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   lat_min = 3;
  int   lat_max = 3;
  bit   hold_ret = 1'b0;
  bit   acc_cpu, acc_vga, s_cpu_wr, s_vga_wr;

  // One clock cycle: present controller returns, observe at negedge, score, advance.
  task automatic cycle();
    bit cpu_hs, vga_hs, m_acc;
    exp_t e;
    logic [DATA_W-1:0] d;
    if (!hold_ret && ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      m_readdatavalid = 1'b1;
      m_readdata      = ret_q[0].data;
      ret_q.delete(0);
    end else begin
      m_readdatavalid = 1'b0;
      m_readdata      = DATA_W'($urandom);
    end
    @(negedge clk);
    s_cpu_wr = cpu_waitrequest;
    s_vga_wr = vga_waitrequest;
    cpu_hs = (cpu_read | cpu_write) & ~cpu_waitrequest;
    vga_hs = vga_read & ~vga_waitrequest;
    m_acc  = (m_read | m_write) & ~m_waitrequest;
    acc_cpu = 1'b0;
    acc_vga = 1'b0;
    if (!reset) begin
      acc_cpu = cpu_hs;
      acc_vga = vga_hs;
      total++;
      if ((cpu_hs | vga_hs) !== m_acc || (cpu_hs && vga_hs)) begin
        bad++;
        $display("FAIL handshake cyc=%0d cpu_hs=%0b vga_hs=%0b master_accept=%0b, need exactly one requester handshake iff master accepts",
                 cyc, cpu_hs, vga_hs, m_acc);
      end
      if (m_readdatavalid) begin
        total++;
        if (exp_q.size() == 0) begin
          if (cpu_readdatavalid !== 1'b0 || vga_readdatavalid !== 1'b0) begin
            bad++;
            $display("FAIL orphan_route cyc=%0d cpu_rdv=%0b vga_rdv=%0b, need 0 0", cyc, cpu_readdatavalid, vga_readdatavalid);
          end
        end else begin
          e = exp_q.pop_front();
          if (cpu_readdatavalid !== ~e.vga || vga_readdatavalid !== e.vga ||
              (e.vga ? vga_readdata : cpu_readdata) !== e.data) begin
            bad++;
            $display("FAIL route cyc=%0d cpu_rdv=%0b vga_rdv=%0b cpu_data=%h vga_data=%h, need vga=%0b data=%h",
                     cyc, cpu_readdatavalid, vga_readdatavalid, cpu_readdata, vga_readdata, e.vga, e.data);
          end
          if (e.vga) vga_got.push_back(vga_readdata);
          else       cpu_got.push_back(cpu_readdata);
        end
      end else begin
        total++;
        if (cpu_readdatavalid !== 1'b0 || vga_readdatavalid !== 1'b0) begin
          bad++;
          $display("FAIL spurious_rdv cyc=%0d cpu_rdv=%0b vga_rdv=%0b, need 0 0", cyc, cpu_readdatavalid, vga_readdatavalid);
        end
      end
      if (cpu_hs) begin
        total++;
        if (m_address !== cpu_address || m_write !== cpu_write || m_read !== ~cpu_write ||
            (cpu_write && (m_writedata !== cpu_writedata || m_byteenable !== cpu_byteenable))) begin
          bad++;
          $display("FAIL cpu_cmd cyc=%0d addr=%h rd=%0b wr=%0b wdata=%h be=%b, need addr=%h wr=%0b wdata=%h be=%b",
                   cyc, m_address, m_read, m_write, m_writedata, m_byteenable,
                   cpu_address, cpu_write, cpu_writedata, cpu_byteenable);
        end
      end
      if (vga_hs) begin
        total++;
        if (m_address !== vga_address || m_read !== 1'b1 || m_write !== 1'b0 || m_byteenable !== 2'b11) begin
          bad++;
          $display("FAIL vga_cmd cyc=%0d addr=%h rd=%0b wr=%0b be=%b, need addr=%h rd=1 wr=0 be=11",
                   cyc, m_address, m_read, m_write, m_byteenable, vga_address);
        end
      end
      if (vga_hs || (cpu_hs && !cpu_write)) begin
        d = (pat_q.size() > 0) ? pat_q.pop_front() : DATA_W'($urandom);
        exp_q.push_back('{vga_hs, d});
        ret_q.push_back('{cyc + int'($urandom_range(lat_min, lat_max)), d});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic issue(input bit vga, input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [DATA_W-1:0] wd, input logic [1:0] be);
    int n = 0;
    if (vga) begin
      vga_read = 1'b1; vga_address = addr;
    end else begin
      cpu_read = ~wr; cpu_write = wr; cpu_address = addr; cpu_writedata = wd; cpu_byteenable = be;
    end
    do begin
      cycle();
      n++;
    end while (!(vga ? acc_vga : acc_cpu) && n < 100);
    total++;
    if (!(vga ? acc_vga : acc_cpu)) begin
      bad++;
      $display("FAIL issue_timeout vga=%0b accepted=0 after %0d cycles, need acceptance", vga, n);
    end
    vga_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    vga_read = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0;
    while ((ret_q.size() > 0 || exp_q.size() > 0) && n < 200) begin
      cycle();
      n++;
    end
    total++;
    if (ret_q.size() != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain ret_left=%0d exp_left=%0d, need 0 0", ret_q.size(), exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; cpu_read = 1'b1; vga_read = 1'b1; hold_ret = 1'b1;
    cycle(); cycle();
    total++;
    if (cpu_waitrequest !== 1'b1 || vga_waitrequest !== 1'b1) begin
      bad++; $display("FAIL reset_wait cpu=%0b vga=%0b, need 1 1", cpu_waitrequest, vga_waitrequest);
    end
    total++;
    if (m_read !== 1'b0 || m_write !== 1'b0) begin
      bad++; $display("FAIL reset_cmd m_read=%0b m_write=%0b, need 0 0", m_read, m_write);
    end
    total++;
    if (cpu_readdatavalid !== 1'b0 || vga_readdatavalid !== 1'b0 || orphan_err !== 1'b0) begin
      bad++; $display("FAIL reset_flags cpu_rdv=%0b vga_rdv=%0b orphan=%0b, need 0 0 0",
                      cpu_readdatavalid, vga_readdatavalid, orphan_err);
    end
    cpu_read = 1'b0; vga_read = 1'b0; hold_ret = 1'b0; reset = 1'b0;
    cycle();
  endtask

  task automatic test_cpu_read();
    lat_min = 3; lat_max = 3; m_waitrequest = 1'b0;
    cpu_got.delete(); vga_got.delete(); pat_q.delete();
    pat_q.push_back(16'hBEEF);
    cpu_read = 1'b1; cpu_address = 22'h000123;
    cycle();
    total++;
    if (s_cpu_wr !== 1'b1) begin
      bad++; $display("FAIL cpu_wait_first cpu_waitrequest=%0b, need 1", s_cpu_wr);
    end
    cycle();
    total++;
    if (s_cpu_wr !== 1'b0 || acc_cpu !== 1'b1) begin
      bad++; $display("FAIL cpu_wait_second cpu_waitrequest=%0b accepted=%0b, need 0 1", s_cpu_wr, acc_cpu);
    end
    cpu_read = 1'b0;
    drain();
    total++;
    if (cpu_got.size() != 1 || cpu_got[0] !== 16'hBEEF || vga_got.size() != 0) begin
      bad++; $display("FAIL cpu_read_data cpu_returns=%0d vga_returns=%0d, need one cpu return of beef", cpu_got.size(), vga_got.size());
    end
  endtask

  task automatic test_vga_burst();
    lat_min = 2; lat_max = 2; m_waitrequest = 1'b0;
    vga_got.delete();
    vga_read = 1'b1; vga_address = 22'h000100;
    for (int k = 0; k < 27; k++) begin
      cycle();
      total++;
      if (acc_vga !== ((k % (VGA_BURST + 1)) != 0)) begin
        bad++; $display("FAIL vga_burst k=%0d accepted=%0b, need %0b", k, acc_vga, (k % (VGA_BURST + 1)) != 0);
      end
      if (acc_vga) vga_address++;
    end
    drain();
    total++;
    if (vga_got.size() != 24) begin
      bad++; $display("FAIL vga_burst_count returns=%0d, need 24", vga_got.size());
    end
  endtask

  task automatic test_starvation();
    int k = 0;
    int t_req = 2;
    int t_acc1 = -1;
    int t_acc2 = -1;
    int vga_between = 0;
    lat_min = 2; lat_max = 2; m_waitrequest = 1'b0;
    vga_read = 1'b1; vga_address = 22'h001000;
    while (t_acc2 < 0 && k < 150) begin
      if (k == t_req) begin
        cpu_write = 1'b1; cpu_address = 22'h3FFFFF; cpu_writedata = 16'h55AA; cpu_byteenable = 2'b11;
      end
      cycle();
      if (acc_vga) begin
        vga_address++;
        if (t_acc1 >= 0) vga_between++;
      end
      if (acc_cpu) begin
        if (t_acc1 < 0) begin
          t_acc1 = k;
          cpu_writedata = 16'h1234;
        end else begin
          t_acc2 = k;
          cpu_write = 1'b0;
        end
      end
      k++;
    end
    total++;
    if (t_acc1 < 0 || t_acc1 - t_req > STARVE_LIMIT + VGA_BURST + 2) begin
      bad++; $display("FAIL starve_latency accepted_at=%0d requested_at=%0d, need within %0d cycles",
                      t_acc1, t_req, STARVE_LIMIT + VGA_BURST + 2);
    end
    total++;
    if (t_acc2 < 0 || vga_between == 0 || t_acc2 - t_acc1 - 1 > STARVE_LIMIT + VGA_BURST + 2) begin
      bad++; $display("FAIL starve_clear vga_reads_between=%0d second_latency=%0d, need VGA served first and latency <= %0d",
                      vga_between, t_acc2 - t_acc1 - 1, STARVE_LIMIT + VGA_BURST + 2);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    int n_acc = 0;
    hold_ret = 1'b1; lat_min = 1; lat_max = 1; m_waitrequest = 1'b0;
    vga_read = 1'b1; vga_address = 22'h002000;
    for (int k = 0; k < 8; k++) begin
      cycle();
      if (acc_vga) begin n_acc++; vga_address++; end
    end
    total++;
    if (n_acc != MAX_PENDING || s_vga_wr !== 1'b1) begin
      bad++; $display("FAIL fifo_full accepted=%0d vga_waitrequest=%0b, need %0d 1", n_acc, s_vga_wr, MAX_PENDING);
    end
    hold_ret = 1'b0;
    cycle();
    total++;
    if (acc_vga !== 1'b1) begin
      bad++; $display("FAIL fifo_slot_freed accepted=%0b, need 1 in the return cycle", acc_vga);
    end
    vga_address++;
    hold_ret = 1'b1;
    cycle();
    total++;
    if (acc_vga !== 1'b0 || s_vga_wr !== 1'b1) begin
      bad++; $display("FAIL fifo_full_again accepted=%0b vga_waitrequest=%0b, need 0 1", acc_vga, s_vga_wr);
    end
    vga_read = 1'b0; hold_ret = 1'b0;
    drain();
  endtask

  task automatic test_interleave();
    hold_ret = 1'b1; lat_min = 1; lat_max = 1; m_waitrequest = 1'b0;
    cpu_got.delete(); vga_got.delete(); pat_q.delete();
    pat_q.push_back(16'h1111); pat_q.push_back(16'h2222); pat_q.push_back(16'h3333);
    issue(1'b0, 1'b0, 22'h000010, '0, 2'b11);
    issue(1'b1, 1'b0, 22'h000020, '0, 2'b11);
    issue(1'b0, 1'b0, 22'h000030, '0, 2'b11);
    hold_ret = 1'b0;
    drain();
    total++;
    if (cpu_got.size() != 2 || cpu_got[0] !== 16'h1111 || cpu_got[1] !== 16'h3333) begin
      bad++; $display("FAIL interleave_cpu returns=%0d, need 1111 then 3333", cpu_got.size());
    end
    total++;
    if (vga_got.size() != 1 || vga_got[0] !== 16'h2222) begin
      bad++; $display("FAIL interleave_vga returns=%0d, need 2222", vga_got.size());
    end
    lat_min = 1; lat_max = 4;
    for (int i = 0; i < 10; i++)
      issue(i[0], 1'b0, ADDR_W'($urandom), '0, 2'b11);
    drain();
  endtask

  task automatic test_random();
    bit c_busy = 1'b0;
    bit wr;
    lat_min = 1; lat_max = 6; hold_ret = 1'b0;
    repeat (800) begin
      if (!c_busy && $urandom_range(0, 3) == 0) begin
        c_busy = 1'b1;
        wr = ($urandom_range(0, 2) == 0);
        cpu_write = wr;
        cpu_read = ~wr | ($urandom_range(0, 7) == 0);
        cpu_address = ADDR_W'($urandom);
        cpu_writedata = DATA_W'($urandom);
        cpu_byteenable = 2'($urandom);
      end
      if (!vga_read && $urandom_range(0, 1) == 0) begin
        vga_read = 1'b1; vga_address = ADDR_W'($urandom);
      end
      m_waitrequest = ($urandom_range(0, 3) == 0);
      cycle();
      if (acc_cpu) begin c_busy = 1'b0; cpu_read = 1'b0; cpu_write = 1'b0; end
      if (acc_vga) begin
        if ($urandom_range(0, 3) != 0) vga_address = ADDR_W'($urandom);
        else vga_read = 1'b0;
      end
    end
    m_waitrequest = 1'b0;
    drain();
    total++;
    if (orphan_err !== 1'b0) begin
      bad++; $display("FAIL random_orphan orphan_err=%0b, need 0", orphan_err);
    end
  endtask

  task automatic test_orphan();
    hold_ret = 1'b1; lat_min = 1; lat_max = 1; m_waitrequest = 1'b0;
    issue(1'b0, 1'b0, 22'h000040, '0, 2'b11);
    issue(1'b1, 1'b0, 22'h000050, '0, 2'b11);
    total++;
    if (orphan_err !== 1'b0) begin
      bad++; $display("FAIL orphan_before orphan_err=%0b, need 0", orphan_err);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    exp_q.delete();
    hold_ret = 1'b0;
    drain();
    repeat (3) cycle();
    total++;
    if (orphan_err !== 1'b1) begin
      bad++; $display("FAIL orphan_sticky orphan_err=%0b, need 1", orphan_err);
    end
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    total++;
    if (orphan_err !== 1'b0) begin
      bad++; $display("FAIL orphan_cleared orphan_err=%0b, need 0", orphan_err);
    end
    cycle();
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_vga_burst();
    test_starvation();
    test_fifo_full();
    test_interleave();
    test_random();
    test_orphan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
- Shares the single SDRAM controller command port between two requesters: CPU load/store (port C) and VGA framebuffer fetch (port V).
- Sits in top between the CPU memory stage / VGA scanout and the SDRAM controller, all on the controller clock domain.
- Tags every issued read so returning read data is routed to the correct requester.
- Guarantees bounded CPU latency under VGA bursts via a starvation counter.

Parameters:
- ADDR_W, 22, word address width (4 banks x 4096 rows x 256 cols).
- DATA_W, 16, data width.
- VGA_BURST, 8, max consecutive VGA reads per grant.
- STARVE_LIMIT, 16, CPU-waiting cycles before the CPU is forced to the next grant.
- MAX_PENDING, 4, outstanding reads tracked (tag FIFO depth, power of 2).

Ports:
- clk  in  1  controller clock.
- reset  in  1  synchronous, active-high reset.
- cpu_address  in  ADDR_W  CPU word address.
- cpu_writedata  in  DATA_W  CPU write data.
- cpu_byteenable  in  2  CPU byte enables, active high.
- cpu_read  in  1  CPU read request.
- cpu_write  in  1  CPU write request.
- cpu_waitrequest  out  1  high = CPU command not accepted this cycle.
- cpu_readdata  out  DATA_W  CPU read data.
- cpu_readdatavalid  out  1  CPU read data strobe.
- vga_address  in  ADDR_W  VGA word address.
- vga_read  in  1  VGA read request.
- vga_waitrequest  out  1  high = VGA command not accepted.
- vga_readdata  out  DATA_W  VGA read data.
- vga_readdatavalid  out  1  VGA read data strobe.
- m_address  out  ADDR_W  address to SDRAM controller.
- m_writedata  out  DATA_W  write data to controller.
- m_byteenable  out  2  byte enables to controller.
- m_read  out  1  read command.
- m_write  out  1  write command.
- m_waitrequest  in  1  controller stall.
- m_readdata  in  DATA_W  controller read data.
- m_readdatavalid  in  1  controller read data strobe.
- orphan_err  out  1  sticky: read data returned with no tag pending.

Behaviour:
- Handshake (Avalon-MM style): requester holds a command stable until its waitrequest is low at a clk edge. A command is accepted when m_read or m_write is high and m_waitrequest is low.
- Waitrequest is high whenever the port is not granted. When granted, it equals m_waitrequest, forced high if the command is a read and the tag FIFO is full.
- FSM states: IDLE, CPU, VGA. State, counters, tag FIFO and orphan_err are registered. Master outputs are combinational muxes of the granted port.
- IDLE: m_read = m_write = 0.
  - Grant VGA if vga_read is high and the starvation counter is below STARVE_LIMIT.
  - Otherwise grant CPU if cpu_read or cpu_write is high.
  - Otherwise grant VGA if vga_read is high.
  - Otherwise stay in IDLE.
  - Minimum arbitration latency: 1 cycle from request to grant.
- CPU state: exactly one command. On acceptance, go to IDLE and clear the starvation counter.
  - cpu_read and cpu_write both high is treated as a write.
  - If the CPU drops its request before acceptance, go to IDLE.
- VGA state: burst counter starts at 0 and increments per accepted read.
  - Go to IDLE after VGA_BURST accepted reads.
  - Go to IDLE when vga_read is low.
  - Go to IDLE when a CPU request is pending and the starvation counter is at or above STARVE_LIMIT, but only at a command boundary, never while a command is presented and stalled.
  - m_write = 0 and m_byteenable = 2'b11 in VGA state.
- Starvation counter: increments (saturating at STARVE_LIMIT) each cycle cpu_read or cpu_write is high and the state is not CPU. Clears on CPU acceptance.
- Tag FIFO: MAX_PENDING entries, 1 bit each (0 = CPU, 1 = VGA).
  - Push on every accepted read.
  - Pop on m_readdatavalid. The popped tag drives cpu_readdatavalid or vga_readdatavalid in the same cycle (combinational).
  - Both readdata outputs are wired to m_readdata.
  - Simultaneous push and pop is allowed even when full; the count is unchanged.
  - Pointers wrap modulo MAX_PENDING.
- Read-data ordering: the controller returns data in issue order, so per-port order is preserved.
- Orphan data: m_readdatavalid with an empty FIFO asserts no readdatavalid and sets orphan_err.
- Reset values:
  - state = IDLE; FIFO empty; counters = 0; orphan_err = 0.
  - m_read = m_write = 0; both waitrequests = 1; both readdatavalids = 0.
  - Reset mid-operation drops all pending tags, so data returning later counts as orphan data.
- Writes produce no read response and no tag.

Test Plan:
- Single CPU read at address 0x000123, controller waitrequest low, data 0xBEEF returned 3 cycles later -> cpu_waitrequest low exactly 1 cycle after the request; cpu_readdatavalid with 0xBEEF; vga_readdatavalid stays 0.
- VGA requesting continuously, no CPU -> grants of 8 reads each, 1 IDLE cycle between bursts; all 8 readdata strobes routed to VGA in order.
- VGA continuous plus CPU write of 0x55AA to 0x3FFFFF issued at cycle 2 -> CPU write accepted within STARVE_LIMIT + VGA_BURST + 2 cycles; m_write high with byteenable 2'b11; starvation counter back to 0.
- Controller withholds data while 5 VGA reads are attempted -> first 4 accepted; 5th held with vga_waitrequest = 1 until one readdatavalid frees a slot, then accepted in that same cycle.
- Interleaved pattern CPU rd, VGA rd, CPU rd -> three returns 0x1111, 0x2222, 0x3333 go to CPU, VGA, CPU respectively; the FIFO pointers wrap after 4+ reads with routing still correct.
- Reset asserted with 2 reads pending, then 2 controller returns -> no readdatavalid on either port; orphan_err = 1 and stays set until the next reset.
